// File: rtl/ssu_serial_peer.sv
// ssu_serial_peer: clocked-synchronous serial slave at the far end of the SSU link.
// Full-duplex byte exchange with a master-mode SSU, plus a one-entry TX holding
// buffer and an RX byte/strobe port on the local (clk) side.
module ssu_serial_peer #(
    parameter bit         CPOL      = 1'b0,
    parameter bit         CPHA      = 1'b0,
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ssck,
    input  logic       scs_n,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       frame_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEL, ST_SHIFT} state_t;

    logic       sck_s1_q, sck_s2_q, sck_s3_q;
    logic       scs_s1_q, scs_s2_q, scs_s3_q;
    logic       sdi_s1_q, sdi_s2_q;

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    logic       frame_err_q, frame_err_d;

    logic       sck_rise, sck_fall, lead, trail;
    logic       cs_fall, cs_rise, active, sample_ev, shift_ev, load;
    logic [7:0] rx_next, tx_next;

    // Two-flop synchronisers plus one history flop for edge detection. The select
    // chain resets to 0 (asserted) so that a reset taken mid-frame never produces a
    // false falling edge; the device then waits for a genuine new select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1_q <= CPOL;
            sck_s2_q <= CPOL;
            sck_s3_q <= CPOL;
            scs_s1_q <= 1'b0;
            scs_s2_q <= 1'b0;
            scs_s3_q <= 1'b0;
            sdi_s1_q <= 1'b0;
            sdi_s2_q <= 1'b0;
        end else begin
            sck_s1_q <= ssck;
            sck_s2_q <= sck_s1_q;
            sck_s3_q <= sck_s2_q;
            scs_s1_q <= scs_n;
            scs_s2_q <= scs_s1_q;
            scs_s3_q <= scs_s2_q;
            sdi_s1_q <= sdi;
            sdi_s2_q <= sdi_s1_q;
        end
    end

    assign sck_rise  = sck_s2_q & ~sck_s3_q;
    assign sck_fall  = ~sck_s2_q & sck_s3_q;
    assign lead      = CPOL ? sck_fall : sck_rise;
    assign trail     = CPOL ? sck_rise : sck_fall;
    assign cs_fall   = ~scs_s2_q & scs_s3_q;
    assign cs_rise   = scs_s2_q & ~scs_s3_q;
    // Edges count only while selected; the release cycle itself still lets a
    // coincident final sample complete.
    assign active    = (state_q != ST_IDLE);
    assign sample_ev = active & (CPHA ? trail : lead);
    assign shift_ev  = active & (CPHA ? lead : trail);
    assign rx_next   = MSB_FIRST ? {rx_shift_q[6:0], sdi_s2_q} : {sdi_s2_q, rx_shift_q[7:1]};
    assign tx_next   = MSB_FIRST ? {tx_shift_q[6:0], 1'b0} : {1'b0, tx_shift_q[7:1]};

    // Next-state: select tracking, bit sampling, shift/load of the TX byte, buffer handshake.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        load        = 1'b0;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d    = ST_SEL;
                bitcnt_d   = 3'd0;
                rx_shift_d = 8'h00;
                load       = !CPHA;
            end
        end else begin
            if (sample_ev) begin
                rx_shift_d = rx_next;
                if (bitcnt_q == 3'd7) begin
                    rx_data_d  = rx_next;
                    rx_valid_d = 1'b1;
                    bitcnt_d   = 3'd0;
                end else begin
                    bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            if (shift_ev) begin
                // Byte boundary loads win over shifting; none on the release cycle.
                if (!cs_rise && bitcnt_q == 3'd0 && (CPHA || state_q == ST_SHIFT)) begin
                    load = 1'b1;
                end else begin
                    tx_shift_d = tx_next;
                end
            end
            if ((lead || trail) && state_q == ST_SEL) begin
                state_d = ST_SHIFT;
            end
            if (cs_rise) begin
                state_d = ST_IDLE;
                if (bitcnt_q != 3'd0 && !(sample_ev && bitcnt_q == 3'd7)) begin
                    frame_err_d = 1'b1;
                    bitcnt_d    = 3'd0;
                end
            end
        end

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = FILL_BYTE;
                underrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign sdo         = MSB_FIRST ? tx_shift_q[7] : tx_shift_q[0];
    assign sdo_oe      = active;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;

endmodule
